// File: rtl/sound_trigger_scheduler.sv
// sound_trigger_scheduler: synchronises and debounces nine request inputs,
// queues rising edges as pending requests and hands them one at a time to a
// voice engine (low-battery first, buttons round-robin), with a busy timeout
// and an idle gap between sounds.
module sound_trigger_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int GAP_CYCLES      = 2500000,
  parameter int BUSY_TIMEOUT    = 255
) (
  input  logic       CLK_50M,
  input  logic       RESET,
  input  logic [7:0] btn,
  input  logic       low_batt_btn,
  output logic       play_start,
  output logic [3:0] play_sel,
  input  logic       play_busy,
  input  logic       play_done,
  output logic [8:0] pending,
  output logic       active,
  output logic       err_timeout
);

  localparam int TICK_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int BUSY_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, PLAY, GAP} state_t;

  logic [8:0]        sync1_reg;
  logic [8:0]        sync2_reg;
  logic [8:0]        sample_reg;
  logic [8:0]        deb_reg;
  logic [8:0]        deb_prev_reg;
  logic [8:0]        pending_reg;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic              tick;
  logic [8:0]        stable;
  logic [8:0]        rise;

  state_t            state_reg;
  logic [3:0]        play_sel_reg;
  logic [2:0]        rr_ptr_reg;
  logic [BUSY_W-1:0] busy_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              play_start_reg;
  logic              active_reg;
  logic              err_reg;

  logic              grant_valid;
  logic [3:0]        grant_idx;
  logic [2:0]        rr_idx;
  logic [8:0]        grant_mask;

  assign tick   = (tick_cnt_reg == TICK_LAST);
  // A bit is accepted only when two consecutive tick samples agree.
  assign stable = ~(sync2_reg ^ sample_reg);
  assign rise   = deb_reg & ~deb_prev_reg;

  // Two-flop synchronisers, shared debounce tick and the two-sample filter
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      sample_reg   <= '0;
      deb_reg      <= '0;
      deb_prev_reg <= '0;
      tick_cnt_reg <= '0;
    end else begin
      sync1_reg    <= {low_batt_btn, btn};
      sync2_reg    <= sync1_reg;
      deb_prev_reg <= deb_reg;
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
      if (tick) begin
        sample_reg <= sync2_reg;
        deb_reg    <= (sync2_reg & stable) | (deb_reg & ~stable);
      end
    end
  end

  // Winner selection: low-battery first, then buttons searched upward from rr_ptr
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 4'd0;
    rr_idx      = 3'd0;
    if (pending_reg[8]) begin
      grant_valid = 1'b1;
      grant_idx   = 4'd8;
    end else begin
      for (int k = 0; k < 8; k++) begin
        rr_idx = rr_ptr_reg + 3'(k);
        if (!grant_valid && pending_reg[rr_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = {1'b0, rr_idx};
        end
      end
    end
  end

  // The pending bit of the request being granted this cycle
  always_comb begin
    grant_mask = '0;
    if (state_reg == IDLE && grant_valid) begin
      grant_mask[grant_idx] = 1'b1;
    end
  end

  // Request queue: a new debounced press overrides a simultaneous grant clear
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= (pending_reg & ~grant_mask) | rise;
    end
  end

  // Playback sequencer with registered outputs
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state_reg      <= IDLE;
      play_sel_reg   <= '0;
      rr_ptr_reg     <= '0;
      busy_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      play_start_reg <= 1'b0;
      active_reg     <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      play_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            play_sel_reg <= grant_idx;
            if (!grant_idx[3]) begin
              rr_ptr_reg <= grant_idx[2:0] + 3'd1;
            end
            active_reg <= 1'b1;
            state_reg  <= START;
          end
        end
        START: begin
          play_start_reg <= 1'b1;
          busy_cnt_reg   <= '0;
          state_reg      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (play_done) begin
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else if (play_busy) begin
            state_reg <= PLAY;
          end else if (busy_cnt_reg == BUSY_LAST) begin
            err_reg     <= 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else begin
            busy_cnt_reg <= busy_cnt_reg + BUSY_W'(1);
          end
        end
        PLAY: begin
          // An engine that drops busy without a done pulse also ends the sound.
          if (play_done || !play_busy) begin
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            active_reg <= 1'b0;
            state_reg  <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        default: begin
          active_reg <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign play_start  = play_start_reg;
  assign play_sel    = play_sel_reg;
  assign pending     = pending_reg;
  assign active      = active_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_sound_trigger_scheduler.sv
// Bench for sound_trigger_scheduler: table of simultaneous-press vectors with
// expected grant order, plus hand sequences for latency, bounce, timeout and
// mid-sound reset. A scoreboard queue holds the expected play_sel of every
// play_start still to come.
module tb_sound_trigger_scheduler;

  localparam int DEB = 4;
  localparam int GAPC = 8;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] btn = 8'h00;
  logic       lb = 1'b0;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic       play_start;
  logic [3:0] play_sel;
  logic [8:0] pending;
  logic       active;
  logic       err_timeout;

  always #10 clk = ~clk;

  sound_trigger_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .GAP_CYCLES(GAPC),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .CLK_50M(clk),
    .RESET(rst),
    .btn(btn),
    .low_batt_btn(lb),
    .play_start(play_start),
    .play_sel(play_sel),
    .play_busy(busy),
    .play_done(done),
    .pending(pending),
    .active(active),
    .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [7:0]  btn;
    logic        lb;
    logic [3:0]  n;
    logic [35:0] grants;   // expected grant order, first grant in the top nibble
  } vec_t;

  vec_t       vecs [7];
  logic [3:0] exp_q [$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_count = 0;
  int last_start_cyc = -1;
  int last_done_cyc = -1;
  int err_cyc = -1;
  int eng_mode = 0;        // 0: normal engine, 1: never busy, 2: busy forever
  int eng_t = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; sample just after the edge, run the engine model and scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (eng_t >= 0) begin
      eng_t++;
      if (eng_t == 1 && eng_mode != 1) busy = 1'b1;
      if (eng_mode == 0 && eng_t == 11) begin
        busy = 1'b0;
        done = 1'b1;
      end
      if (eng_mode == 0 && eng_t == 12) begin
        done  = 1'b0;
        eng_t = -1;
      end
      if (eng_mode != 0 && eng_t == 1) eng_t = -1;
    end
    if (done) last_done_cyc = cyc;
    if (err_timeout && err_cyc < 0) err_cyc = cyc;
    if (play_start) begin
      start_count++;
      last_start_cyc = cyc;
      eng_t = 0;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_start: play_start with play_sel=%0d, none expected (cycle %0d)", play_sel, cyc);
      end else begin
        check("grant_sel", {28'd0, play_sel}, {28'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    btn = 8'h00;
    lb = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    eng_mode = 0;
    eng_t = -1;
    step();
    step();
    rst = 1'b0;
    start_count = 0;
    last_start_cyc = -1;
    last_done_cyc = -1;
    err_cyc = -1;
  endtask

  task automatic press(input logic [7:0] b, input logic l, input int hold);
    btn = b;
    lb = l;
    for (int i = 0; i < hold; i++) step();
    btn = 8'h00;
    lb = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    for (int i = 0; i < budget && start_count < target; i++) step();
    check("start_count", start_count, target);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (active || pending != 0); i++) step();
    check("idle_reached", {22'd0, pending, active}, 32'd0);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not complete, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int p_cyc;
    int w_cyc;
    int fall_cyc;
    int base;
    logic [8:0] pend_seen;
    logic [8:0] pend_or;

    vecs[0] = '{btn: 8'h22, lb: 1'b1, n: 4'd3, grants: 36'h815000000};
    vecs[1] = '{btn: 8'h81, lb: 1'b0, n: 4'd2, grants: 36'h700000000};
    vecs[2] = '{btn: 8'h04, lb: 1'b0, n: 4'd1, grants: 36'h200000000};
    vecs[3] = '{btn: 8'h09, lb: 1'b0, n: 4'd2, grants: 36'h300000000};
    vecs[4] = '{btn: 8'h00, lb: 1'b1, n: 4'd1, grants: 36'h800000000};
    vecs[5] = '{btn: 8'h03, lb: 1'b0, n: 4'd2, grants: 36'h100000000};
    vecs[6] = '{btn: 8'hFF, lb: 1'b1, n: 4'd9, grants: 36'h812345670};

    // Reset state
    apply_reset();
    check("rst_play_start", {31'd0, play_start}, 32'd0);
    check("rst_play_sel", {28'd0, play_sel}, 32'd0);
    check("rst_pending", {23'd0, pending}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);

    // Single press: latency, selection, gap length
    apply_reset();
    exp_q.push_back(4'd2);
    p_cyc = -1;
    pend_seen = '0;
    btn = 8'h04;
    for (int i = 0; i < 20; i++) begin
      step();
      if (p_cyc < 0 && pending != 0) begin
        p_cyc = cyc;
        pend_seen = pending;
      end
    end
    btn = 8'h00;
    wait_starts(1, 40);
    check("pending_bit", {23'd0, pend_seen}, 32'h004);
    check("start_latency", last_start_cyc - p_cyc, 32'd2);
    for (int i = 0; i < 30 && last_done_cyc < last_start_cyc; i++) step();
    for (int i = 0; i < 40 && active; i++) step();
    fall_cyc = cyc;
    check("active_fall", fall_cyc - last_done_cyc, GAPC + 1);
    for (int i = 0; i < 20; i++) step();
    check("single_starts", start_count, 32'd1);
    check("single_pending", {23'd0, pending}, 32'd0);
    check("single_sel_held", {28'd0, play_sel}, 32'd2);
    check("single_queue", exp_q.size(), 32'd0);

    // Bounce on btn[0], then a pulse on btn[1] only one tick long
    apply_reset();
    pend_or = '0;
    for (int i = 0; i < 90; i++) begin
      btn = 8'h00;
      if (i < 30) btn[0] = ((i / 2) % 2) == 1;
      if (i >= 60 && i < 64) btn[1] = 1'b1;
      step();
      pend_or = pend_or | pending;
    end
    btn = 8'h00;
    check("bounce_pending", {23'd0, pend_or}, 32'd0);
    check("bounce_starts", start_count, 32'd0);

    // Table: simultaneous presses, arbitration order carried across vectors
    apply_reset();
    for (int v = 0; v < 7; v++) begin
      base = start_count;
      for (int k = 0; k < int'(vecs[v].n); k++) exp_q.push_back(vecs[v].grants[35 - 4*k -: 4]);
      press(vecs[v].btn, vecs[v].lb, 16);
      for (int i = 0; i < 400 && (start_count - base < int'(vecs[v].n) || active); i++) step();
      check("vec_grants", start_count - base, {28'd0, vecs[v].n});
      check("vec_pending", {23'd0, pending}, 32'd0);
      check("vec_queue", exp_q.size(), 32'd0);
      $display("[TB] vector %0d btn=%02h lb=%0d grants=%0d", v, vecs[v].btn, vecs[v].lb, start_count - base);
      for (int i = 0; i < 16; i++) step();
    end

    // Busy timeout, with a second queued request still served
    apply_reset();
    eng_mode = 1;
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd6);
    press(8'h48, 1'b0, 16);
    wait_starts(1, 40);
    w_cyc = last_start_cyc;
    wait_starts(2, 100);
    check("err_delay", err_cyc - w_cyc, TMO);
    wait_idle(100);
    check("err_sticky", {31'd0, err_timeout}, 32'd1);
    check("tmo_queue", exp_q.size(), 32'd0);

    // Reset in the middle of a sound with two requests queued
    apply_reset();
    eng_mode = 2;
    exp_q.push_back(4'd2);
    press(8'h04, 1'b0, 16);
    wait_starts(1, 20);
    press(8'h03, 1'b0, 16);
    for (int i = 0; i < 20 && pending != 9'h003; i++) step();
    check("mid_pending", {23'd0, pending}, 32'h003);
    check("mid_active", {31'd0, active}, 32'd1);
    rst = 1'b1;
    eng_mode = 0;
    eng_t = -1;
    busy = 1'b0;
    step();
    check("mrst_play_start", {31'd0, play_start}, 32'd0);
    check("mrst_play_sel", {28'd0, play_sel}, 32'd0);
    check("mrst_pending", {23'd0, pending}, 32'd0);
    check("mrst_active", {31'd0, active}, 32'd0);
    check("mrst_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    pend_or = '0;
    for (int i = 0; i < 60; i++) begin
      step();
      pend_or = pend_or | pending;
    end
    check("mrst_no_start", start_count, 32'd1);
    check("mrst_no_pending", {23'd0, pend_or}, 32'd0);
    exp_q.push_back(4'd4);
    press(8'h10, 1'b0, 16);
    wait_starts(2, 40);
    wait_idle(60);
    check("mrst_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
